// File: rtl/cga_trap_pkg.sv
// rtl/cga_trap_pkg.sv - shared types and constants for the CGA trap acceptance sequencer
package cga_trap_pkg;

    localparam int VEC_W  = 4;
    localparam int PEND_W = 16;

    localparam logic [VEC_W-1:0] VEC_NONE = 4'd0;
    localparam logic [VEC_W-1:0] VEC_MAX  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } trap_state_e;

    function automatic logic [PEND_W-1:0] vec_onehot(input logic [VEC_W-1:0] v);
        logic [PEND_W-1:0] r;
        r    = '0;
        r[v] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/cga_trap_prienc.sv
// rtl/cga_trap_prienc.sv - 16-to-4 lowest-index priority encoder with valid flag
module cga_trap_prienc
    import cga_trap_pkg::*;
(
    input  logic [PEND_W-1:0] req,
    output logic [VEC_W-1:0]  idx,
    output logic              valid
);

    // Scanning downwards lets the lowest set bit be the last one assigned.
    always_comb begin
        idx   = VEC_NONE;
        valid = 1'b0;
        for (int i = PEND_W - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = i[VEC_W-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cga_trap_seq.sv
// rtl/cga_trap_seq.sv - trap pending register, request/ack FSM and IIC readout register
module cga_trap_seq
    import cga_trap_pkg::*;
(
    input  logic              TCLK,
    input  logic              RST,
    input  logic              TRAPN,
    input  logic [VEC_W-1:0]  TVEC_3_0,
    input  logic              BRKN,
    input  logic              PVIOL,
    input  logic              RESTR,
    input  logic              MBOUND,
    input  logic              TACK,
    input  logic [PEND_W-1:0] IIE_15_0,
    input  logic              IICRD,
    output logic              TREQ,
    output logic [VEC_W-1:0]  TCODE_3_0,
    output logic [VEC_W-1:0]  IIC_3_0,
    output logic              IICV,
    output logic              IICOVF,
    output logic [PEND_W-1:0] PEND_15_0,
    output logic              RESTRL,
    output logic              BRKL
);

    trap_state_e       state_q, state_d;
    logic [VEC_W-1:0]  tcode_q, tcode_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [PEND_W-1:0] rs_q, rs_d;
    logic [PEND_W-1:0] bk_q, bk_d;
    logic [VEC_W-1:0]  iic_q, iic_d;
    logic              iicv_q, iicv_d;
    logic              iicovf_q, iicovf_d;
    logic              restrl_q, restrl_d;
    logic              brkl_q, brkl_d;

    logic [PEND_W-1:0] cap_set;
    logic [PEND_W-1:0] ack_clr;
    logic [PEND_W-1:0] eligible;
    logic [VEC_W-1:0]  win_idx;
    logic              win_valid;

    assign eligible = pend_q & IIE_15_0;

    cga_trap_prienc u_prienc (
        .req   (eligible),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // Capture is ORed in after the ACK clear so a same-edge re-trap survives.
    always_comb begin
        cap_set = '0;
        if (!TRAPN && (TVEC_3_0 != VEC_NONE)) begin
            cap_set = vec_onehot(TVEC_3_0);
        end
        ack_clr = '0;
        if (state_q == ST_ACK) begin
            ack_clr = vec_onehot(tcode_q);
        end
        pend_d = (pend_q & ~ack_clr) | cap_set;
        rs_d   = (rs_q & ~cap_set) | (cap_set & {PEND_W{RESTR | PVIOL}});
        bk_d   = (bk_q & ~cap_set) | (cap_set & {PEND_W{~BRKN}});
    end

    always_comb begin
        state_d  = state_q;
        tcode_d  = tcode_q;
        iic_d    = iic_q;
        iicv_d   = iicv_q;
        iicovf_d = iicovf_q;
        restrl_d = restrl_q;
        brkl_d   = brkl_q;
        if (IICRD) begin
            iicv_d   = 1'b0;
            iicovf_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (MBOUND && win_valid) begin
                    state_d = ST_REQ;
                    tcode_d = win_idx;
                end
            end
            ST_REQ: begin
                if (TACK) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                // A read landing on the ACK edge consumed the old code, so no overflow.
                state_d  = ST_IDLE;
                iic_d    = tcode_q;
                iicv_d   = 1'b1;
                iicovf_d = iicv_q & ~IICRD;
                restrl_d = rs_q[tcode_q];
                brkl_d   = bk_q[tcode_q];
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge TCLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            tcode_q  <= VEC_NONE;
            pend_q   <= '0;
            rs_q     <= '0;
            bk_q     <= '0;
            iic_q    <= VEC_NONE;
            iicv_q   <= 1'b0;
            iicovf_q <= 1'b0;
            restrl_q <= 1'b0;
            brkl_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcode_q  <= tcode_d;
            pend_q   <= pend_d;
            rs_q     <= rs_d;
            bk_q     <= bk_d;
            iic_q    <= iic_d;
            iicv_q   <= iicv_d;
            iicovf_q <= iicovf_d;
            restrl_q <= restrl_d;
            brkl_q   <= brkl_d;
        end
    end

    assign TREQ      = (state_q == ST_REQ);
    assign TCODE_3_0 = tcode_q;
    assign IIC_3_0   = iic_q;
    assign IICV      = iicv_q;
    assign IICOVF    = iicovf_q;
    assign PEND_15_0 = pend_q;
    assign RESTRL    = restrl_q;
    assign BRKL      = brkl_q;

endmodule

// File: doc/cga_trap_seq.md
# cga_trap_seq

Trap acceptance sequencer directly downstream of the CGA trap detector. Latches detected trap vectors into a 16-bit pending (IID-style) register, masks them with the internal-interrupt enable, selects the winning vector at a microprogram boundary and hands it to the microsequencer with a request/acknowledge handshake. It then holds the accepted code in an IIC-style register for software readout.

## Interface
No parameters; widths are fixed by the ND-120 vector format.
- TCLK  in  1  CPU clock; all state changes on rising edge
- RST  in  1  reset; asynchronous, active-high
- TRAPN  in  1  low = trap detected this cycle; qualifies TVEC_3_0
- TVEC_3_0  in  4  trap vector from the trap detector; 0 = none
- BRKN  in  1  low = breakpoint match this cycle
- PVIOL  in  1  protect violation flag accompanying the trap
- RESTR  in  1  faulting instruction must be restarted
- MBOUND  in  1  microsequencer is at a trap-sampling boundary
- TACK  in  1  microsequencer accepts the presented trap
- IIE_15_0  in  16  internal-interrupt enable mask; bit n enables vector n
- IICRD  in  1  one-cycle strobe: IIC register read by software
- TREQ  out  1  trap request to the microsequencer
- TCODE_3_0  out  4  vector presented with TREQ
- IIC_3_0  out  4  last accepted vector
- IICV  out  1  IIC holds an unread code
- IICOVF  out  1  an accepted code overwrote an unread one
- PEND_15_0  out  16  pending trap bits
- RESTRL  out  1  RESTR latched for the accepted trap
- BRKL  out  1  breakpoint latched for the accepted trap

## Operation
- Capture: an edge with TRAPN=0 and TVEC_3_0≠0 sets PEND[TVEC]. TVEC=0 is ignored, and PEND[0] is always 0. Each set of PEND[v] also loads that vector's side flags into per-vector shadow bits: restart = RESTR|PVIOL, brk = !BRKN.
- Eligible set = PEND & IIE. Winner = lowest-numbered eligible bit.
- FSM states: IDLE, REQ, ACK.
  - IDLE: if MBOUND=1 and eligible≠0 → REQ; the winner is frozen into TCODE.
  - REQ: TREQ=1 and TCODE is held stable; mask and PEND changes do not alter TCODE. TACK=1 → ACK. The request is never withdrawn.
  - ACK (one cycle): clear PEND[TCODE]; IIC←TCODE; IICOVF←IICV; IICV←1; RESTRL/BRKL←shadow bits of TCODE → IDLE.
- IICRD=1 clears IICV and IICOVF. In the same cycle as ACK, ACK wins: IICV=1 and IICOVF=0.
- A capture and an ACK clear of the same bit in one edge: capture wins and the bit stays set.
- TACK outside REQ is ignored. MBOUND outside IDLE is ignored.

## Timing
- Reset: all outputs 0, PEND=0, state IDLE, shadow bits 0.
- Capture latency: PEND visible 1 cycle after the sampling edge.
- TREQ rises at the edge that samples MBOUND=1 with eligible≠0 in IDLE.
- Fastest turnaround: TACK in the first REQ cycle. Then ACK is the next cycle, IIC/IICV update at the end of ACK, and the next TREQ is possible 1 cycle after ACK (IDLE sampling).
- An RST assertion mid-REQ/ACK drops TREQ immediately and discards the pending and in-flight trap.

## Structure
- Package cga_trap_pkg: state enum (IDLE/REQ/ACK), vector width 4, pending width 16, named vector constants.
- Sub-module cga_trap_prienc: 16→4 lowest-index priority encoder with valid output, purely combinational.
- Top: PEND/shadow registers, FSM, IIC register.

## Test plan
- Reset mid-REQ: RST pulse → TREQ, PEND and IIC go to 0 asynchronously, FSM in IDLE afterwards.
- Single trap: TRAPN=0, TVEC=5, IIE=0xFFFF, MBOUND=1 → PEND=0x0020, next edge TREQ=1 TCODE=5. TACK → ACK cycle, then IIC=5, IICV=1, PEND=0.
- Priority and mask: capture vectors 3 and 9 with IIE=0xFFF7 → TCODE=9. Set IIE bit 3 while in REQ → TCODE stays 9. After ACK, the next request presents 3.
- Overwrite: accept vector 2 without IICRD, then accept vector 4 → IIC=4, IICOVF=1. An IICRD pulse clears IICV and IICOVF.
- Simultaneous capture/clear: new TRAPN=0 TVEC=6 on the ACK edge of vector 6 → PEND[6] remains 1 and TREQ reasserts at the next MBOUND.
- Side flags: TVEC=12 with RESTR=1, BRKN=0 → after ACK, RESTRL=1 and BRKL=1. TVEC=0 with TRAPN=0 → PEND unchanged.
